// File: rtl/calc_pkg.sv
// Shared definitions for the calc scheduler: opcodes, FSM states,
// latched command bundle and the opcode-to-latency-class mapping.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_EXP = 3'b100;
    localparam logic [2:0] OP_LOG = 3'b101;
    localparam logic [2:0] OP_POW = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LC_ADDSUB = 2'd0,
        LC_MULDIV = 2'd1,
        LC_EXT    = 2'd2
    } lat_class_t;

    typedef struct packed {
        logic        id;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    function automatic lat_class_t lat_class(input logic [2:0] op);
        lat_class_t c;
        case (op)
            OP_ADD, OP_SUB:         c = LC_ADDSUB;
            OP_MUL, OP_DIV, OP_MOD: c = LC_MULDIV;
            default:                c = LC_EXT;
        endcase
        return c;
    endfunction

    // Ops whose result is undefined when the divisor is zero.
    function automatic logic div_like(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/calc_rr_arb2.sv
// Two-way round-robin arbiter: grants the lone valid requester, or the
// prio requester on contention; prio flips to the loser on each take.
module calc_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       take,
    output logic       grant_any,
    output logic       grant_id
);

    logic prio;

    always_comb begin
        grant_id = 1'b0;
        if (valid[0] && valid[1]) begin
            grant_id = prio;
        end else if (valid[1]) begin
            grant_id = 1'b1;
        end
    end

    assign grant_any = |valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio <= 1'b0;
        end else if (take) begin
            prio <= ~grant_id;
        end
    end

endmodule

// File: rtl/calc_sched_16.sv
// Schedules commands from two requesters onto one shared multi-cycle
// calc unit. Ports: req0/req1 valid/ready/op/a/b, rsp valid/ready/id/
// data/sign/err, calc_* drive/result to the unit, busy status.
module calc_sched_16
    import calc_pkg::*;
#(
    parameter int unsigned LAT_ADDSUB = 1,
    parameter int unsigned LAT_MULDIV = 16,
    parameter int unsigned LAT_EXT    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_sign,
    output logic        rsp_err,
    output logic        calc_enable,
    output logic [2:0]  calc_operation,
    output logic [15:0] calc_opa,
    output logic [15:0] calc_opb,
    input  logic [15:0] calc_sum,
    input  logic        calc_sign,
    output logic        busy
);

    localparam logic [5:0] L_AS = 6'(LAT_ADDSUB);
    localparam logic [5:0] L_MD = 6'(LAT_MULDIV);
    localparam logic [5:0] L_EX = 6'(LAT_EXT);

    state_t      state;
    state_t      state_nx;
    cmd_t        cmd;
    cmd_t        in_cmd;
    logic [5:0]  cnt;
    logic [5:0]  lat_sel;
    logic        grant_any;
    logic        grant_id;
    logic        accept;
    logic        div0;

    calc_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     ({req1_valid, req0_valid}),
        .take      (accept),
        .grant_any (grant_any),
        .grant_id  (grant_id)
    );

    always_comb begin
        in_cmd.id = grant_id;
        in_cmd.op = grant_id ? req1_op : req0_op;
        in_cmd.a  = grant_id ? req1_a  : req0_a;
        in_cmd.b  = grant_id ? req1_b  : req0_b;
    end

    always_comb begin
        lat_sel = L_EX;
        case (lat_class(in_cmd.op))
            LC_ADDSUB: lat_sel = L_AS;
            LC_MULDIV: lat_sel = L_MD;
            default:   lat_sel = L_EX;
        endcase
    end

    assign accept = (state == ST_IDLE) && grant_any;
    assign div0   = div_like(in_cmd.op) && (in_cmd.b == 16'h0000);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = div0 ? ST_RESP : ST_RUN;
                end
            end
            // cnt==1 is the last enabled cycle; it decrements to zero here.
            ST_RUN:  if (cnt <= 6'd1) state_nx = ST_CAPT;
            ST_CAPT: state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd      <= '0;
            cnt      <= 6'd0;
            rsp_data <= 16'h0000;
            rsp_sign <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                cmd <= in_cmd;
                cnt <= div0 ? 6'd0 : lat_sel;
                if (div0) begin
                    rsp_data <= 16'hFFFF;
                    rsp_sign <= 1'b0;
                    rsp_err  <= 1'b1;
                end
            end
            if (state == ST_RUN && cnt != 6'd0) begin
                cnt <= cnt - 6'd1;
            end
            if (state == ST_CAPT) begin
                rsp_data <= calc_sum;
                rsp_sign <= calc_sign;
                rsp_err  <= 1'b0;
            end
        end
    end

    assign calc_enable    = (state == ST_RUN);
    assign calc_operation = cmd.op;
    assign calc_opa       = cmd.a;
    assign calc_opb       = cmd.b;
    assign rsp_valid      = (state == ST_RESP);
    assign rsp_id         = cmd.id;
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_calc_sched_16.sv
// Self-checking bench for calc_sched_16 with a behavioural calc unit
// and a scoreboard queue of expected responses.
module tb_calc_sched_16;
    import calc_pkg::*;

    localparam int LAT_AS = 1;
    localparam int LAT_MD = 16;
    localparam int LAT_EX = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic        rsp_id, rsp_sign, rsp_err;
    logic [15:0] rsp_data;
    logic        calc_enable;
    logic [2:0]  calc_operation;
    logic [15:0] calc_opa, calc_opb;
    logic [15:0] calc_sum;
    logic        calc_sign;
    logic        busy;

    always #5 clk = ~clk;

    calc_sched_16 #(
        .LAT_ADDSUB(LAT_AS), .LAT_MULDIV(LAT_MD), .LAT_EXT(LAT_EX)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_sign(rsp_sign), .rsp_err(rsp_err),
        .calc_enable(calc_enable), .calc_operation(calc_operation),
        .calc_opa(calc_opa), .calc_opb(calc_opb),
        .calc_sum(calc_sum), .calc_sign(calc_sign),
        .busy(busy)
    );

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        sign;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int errors  = 0;

    function automatic logic [15:0] unit_sum(input logic [2:0] op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
        logic [15:0] p;
        case (op)
            OP_ADD:  p = a + b;
            OP_SUB:  p = a - b;
            default: begin
                p = a * b;
                p = p ^ {13'd0, op} ^ 16'h5a00;
            end
        endcase
        return p;
    endfunction

    function automatic logic unit_sign(input logic [2:0] op,
                                       input logic [15:0] a,
                                       input logic [15:0] b);
        logic [15:0] s;
        s = unit_sum(op, a, b);
        return (op == OP_SUB) ? (a < b) : s[15];
    endfunction

    assign calc_sum  = unit_sum(calc_operation, calc_opa, calc_opb);
    assign calc_sign = unit_sign(calc_operation, calc_opa, calc_opb);

    function automatic bit is_div0(input logic [2:0] op, input logic [15:0] b);
        return (op == OP_DIV || op == OP_MOD) && (b == 16'd0);
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB:         return LAT_AS;
            OP_MUL, OP_DIV, OP_MOD: return LAT_MD;
            default:                return LAT_EX;
        endcase
    endfunction

    task automatic push_exp(input logic id, input logic [2:0] op,
                            input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.id = id;
        if (is_div0(op, b)) begin
            e.data = 16'hFFFF; e.sign = 1'b0; e.err = 1'b1;
        end else begin
            e.data = unit_sum(op, a, b);
            e.sign = unit_sign(op, a, b);
            e.err  = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after accept.
    task automatic issue(input logic id, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        vectors++;
        if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL issue_ready id=%0d got=%b want=%b", id,
                     {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        end
        push_exp(id, op, a, b);
        @(negedge clk);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    // Starts at the negedge of cycle T+1 (accept in cycle T).
    task automatic wait_rsp(input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input int stall);
        exp_t e;
        int   lat;
        int   want;
        int   k;
        int   en;
        bit   held;
        lat  = is_div0(op, b) ? 0 : exp_lat(op);
        want = is_div0(op, b) ? 1 : lat + 2;
        k = 1; en = 0; held = 1'b1;
        rsp_ready = (stall == 0);
        while (!rsp_valid && k < 300) begin
            en += int'(calc_enable);
            if (calc_operation !== op || calc_opa !== a || calc_opb !== b)
                held = 1'b0;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
                held = 1'b0;
            @(negedge clk);
            k++;
        end
        vectors++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout op=%0d got no rsp_valid want one", op);
            if (sb.size() > 0) void'(sb.pop_front());
            rsp_ready = 1'b1;
            return;
        end
        vectors++;
        if (k != want) begin
            errors++;
            $display("FAIL latency op=%0d got=%0d want=%0d", op, k, want);
        end
        vectors++;
        if (en != lat) begin
            errors++;
            $display("FAIL enable_cycles op=%0d got=%0d want=%0d", op, en, lat);
        end
        vectors++;
        if (!held) begin
            errors++;
            $display("FAIL run_hold op=%0d got=unstable want=stable", op);
        end
        e = sb.pop_front();
        vectors++;
        if ({rsp_id, rsp_data, rsp_sign, rsp_err} !==
            {e.id, e.data, e.sign, e.err}) begin
            errors++;
            $display("FAIL rsp_fields got id=%0d d=%h s=%0d e=%0d want id=%0d d=%h s=%0d e=%0d",
                     rsp_id, rsp_data, rsp_sign, rsp_err,
                     e.id, e.data, e.sign, e.err);
        end
        for (int i = 1; i < stall; i++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_sign, rsp_err,
                 req0_ready, req1_ready, calc_enable} !==
                {1'b1, e.id, e.data, e.sign, e.err, 3'b000}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%0d d=%h r=%b%b want v=1 d=%h r=00",
                         i, rsp_valid, rsp_data, req1_ready, req0_ready, e.data);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rsp_done got v=%0d busy=%0d want v=0 busy=0",
                     rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, rsp_valid, rsp_id, rsp_data, rsp_sign, rsp_err,
             calc_enable, calc_operation, calc_opa, calc_opb,
             req0_ready, req1_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%0d v=%0d d=%h en=%0d op=%0d a=%h b=%h want all zero",
                     busy, rsp_valid, rsp_data, calc_enable,
                     calc_operation, calc_opa, calc_opb);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        issue(1'b0, OP_ADD, 16'd5, 16'd3);
        wait_rsp(OP_ADD, 16'd5, 16'd3, 0);
    endtask

    task automatic test_contention();
        logic       g;
        logic [2:0] op;
        logic [15:0] a, b;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req0_op = OP_MUL; req0_a = 16'd7; req0_b = 16'd9;
        req1_op = OP_SUB; req1_a = 16'd3; req1_b = 16'd10;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g = i[0];
            #1;
            vectors++;
            if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL contention_grant n=%0d got=%b want=%b", i,
                         {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
            end
            op = g ? req1_op : req0_op;
            a  = g ? req1_a  : req0_a;
            b  = g ? req1_b  : req0_b;
            push_exp(g, op, a, b);
            @(negedge clk);
            wait_rsp(op, a, b, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        issue(1'b1, OP_DIV, 16'd9, 16'd0);
        wait_rsp(OP_DIV, 16'd9, 16'd0, 0);
        issue(1'b0, OP_MOD, 16'd4, 16'd0);
        wait_rsp(OP_MOD, 16'd4, 16'd0, 0);
    endtask

    task automatic test_backpressure();
        issue(1'b0, OP_ADD, 16'd100, 16'd23);
        req1_op = OP_SUB; req1_a = 16'd50; req1_b = 16'd60;
        req1_valid = 1'b1;
        wait_rsp(OP_ADD, 16'd100, 16'd23, 5);
        #1;
        vectors++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL waiting_req got ready=%0d want 1", req1_ready);
        end
        push_exp(1'b1, OP_SUB, 16'd50, 16'd60);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(OP_SUB, 16'd50, 16'd60, 0);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        issue(1'b0, OP_MUL, 16'd300, 16'd200);
        void'(sb.pop_back());
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, calc_enable, rsp_valid, calc_operation} !== '0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%0d en=%0d v=%0d op=%0d want 0",
                     busy, calc_enable, rsp_valid, calc_operation);
        end
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || calc_enable) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL midrun_discard got activity want none");
        end
    endtask

    task automatic test_lat_sweep();
        issue(1'b1, OP_EXP, 16'd3, 16'd4);
        wait_rsp(OP_EXP, 16'd3, 16'd4, 0);
    endtask

    task automatic test_back_to_back();
        logic       id;
        logic [2:0] op;
        logic [15:0] a, b;
        for (int i = 0; i < 8; i++) begin
            id = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            issue(id, op, a, b);
            wait_rsp(op, a, b, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_add();
        test_contention();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        test_lat_sweep();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/calc_sched_16.md
CALC_SCHED_16 -- requirements
Module: calc_sched_16

Interface
REQ-001 Parameter LAT_ADDSUB, default 1, SHALL set calc-unit cycles for ops 000/001 (range 1-63).
REQ-002 Parameter LAT_MULDIV, default 16, SHALL set calc-unit cycles for ops 010/011/111 (range 1-63).
REQ-003 Parameter LAT_EXT, default 32, SHALL set calc-unit cycles for ops 100/101/110 (range 1-63).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 req0_valid/req1_valid  in  1  requester N has a command.
REQ-007 req0_ready/req1_ready  out  1  command from requester N accepted this cycle.
REQ-008 req0_op/req1_op  in  3  opcode (000 add, 001 sub, 010 mul, 011 div, 100 A*exp(B), 101 log_A(B), 110 A^B, 111 mod).
REQ-009 req0_a, req0_b, req1_a, req1_b  in  16  operands.
REQ-010 rsp_valid  out  1  response available; rsp_ready  in  1  consumer accepts.
REQ-011 rsp_id  out  1  requester index; rsp_data  out  16  result; rsp_sign  out  1  sign; rsp_err  out  1  divide-by-zero.
REQ-012 calc_enable  out  1; calc_operation  out  3; calc_opa, calc_opb  out  16  drive to the shared calc unit.
REQ-013 calc_sum  in  16; calc_sign  in  1  result from the calc unit.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, RUN, CAPT, RESP.
REQ-016 In IDLE with any reqN_valid, the arbiter SHALL grant exactly one requester, and reqN_ready SHALL be high that cycle (combinational from valid and state).
REQ-017 Grant: one valid -> that requester; both valid -> requester equal to prio pointer; prio SHALL be set to the non-granted index after each grant.
REQ-018 On accept, op/a/b/id SHALL be latched, and calc_operation/opa/opb SHALL be held stable from the latched values until the next accept.
REQ-019 Accept of op 011 or 111 with b==0 SHALL go to RESP with rsp_data=16'hFFFF, rsp_sign=0, rsp_err=1; calc_enable SHALL never assert.
REQ-020 Otherwise, accept SHALL go to RUN with counter loaded to the op latency; calc_enable SHALL be high for exactly LAT consecutive cycles in RUN.
REQ-021 CAPT SHALL last one cycle with calc_enable=0, registering calc_sum->rsp_data, calc_sign->rsp_sign, rsp_err=0.
REQ-022 Latency: accept in cycle T -> rsp_valid first high in cycle T+LAT+2; div-by-zero -> T+1.
REQ-023 RESP SHALL hold rsp_valid and all rsp_* stable until rsp_valid&rsp_ready, then go to IDLE next cycle.
REQ-024 reqN_ready SHALL be low in every state except IDLE; requester valid arriving while busy SHALL wait, not be dropped.
REQ-025 In RESP with rsp_ready already high, the response SHALL complete in one cycle; no new accept SHALL occur in that same cycle.
REQ-026 Counter SHALL be 6 bits and never wrap; RUN SHALL exit when the count reaches zero.

Reset
REQ-027 rst low at a clock edge SHALL, in any state, force IDLE, prio=0, counter=0, calc_enable=0, calc_operation=0, calc_opa=0, calc_opb=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_sign=0, rsp_err=0, busy=0.
REQ-028 Reset mid-RUN or mid-RESP SHALL discard the in-flight command; no response SHALL be issued for it.

Structure
REQ-029 Package calc_pkg SHALL hold opcode constants OP_ADD..OP_MOD, FSM state encoding, and the opcode-to-latency-class function.
REQ-030 Sub-module calc_rr_arb2 SHALL implement the two-way round-robin grant and prio pointer.

Verification
REQ-031 Single add: req0 op=000 a=5 b=3, LAT_ADDSUB=1, calc_sum returns 8 -> ready at T, calc_enable high T+1 only, rsp_valid at T+3, rsp_data=8, rsp_id=0, rsp_err=0.
REQ-032 Contention: req0 and req1 both valid from reset -> grants in order 0,1,0,1 over four commands, rsp_id matching each grant.
REQ-033 Div-by-zero: req1 op=011 a=9 b=0 -> rsp_valid at T+1, rsp_data=FFFF, rsp_err=1, calc_enable never high.
REQ-034 Backpressure: rsp_ready low 5 cycles during RESP -> rsp_* stable, req ready stays low, then completes on the cycle rsp_ready rises.
REQ-035 Reset mid-RUN: op=010 with LAT_MULDIV=16, rst low at cycle 8 of RUN -> next cycle IDLE, calc_enable=0, no rsp_valid afterwards.
REQ-036 Latency sweep: op 100 with LAT_EXT=32 -> calc_enable high exactly 32 cycles, rsp_valid at T+34.
